traffic_phase_controller: RTL and testbench

//  Next-generation single-approach traffic light sequencer with parametrised phase timings.
//  - Per-state dwell timer replaces the shared free-running count.
//  - Car sensor extends green up to a maximum; pedestrian requests are latched.
//  - A dedicated WALK phase with acknowledge is added.
//  - Sits between debounced sensor inputs and the lamp driver / pedestrian signal head.

---
 rtl/tpc_pkg.sv | 15 +
 rtl/tpc_dwell_timer.sv | 25 ++
 rtl/traffic_phase_controller.sv | 168 ++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// Shared encodings for the traffic phase controller: state codes and lamp codes.
package tpc_pkg;

  localparam logic [2:0] S_ALL_RED = 3'd0;
  localparam logic [2:0] S_GREEN   = 3'd1;
  localparam logic [2:0] S_YELLOW  = 3'd2;
  localparam logic [2:0] S_WALK    = 3'd3;
  localparam logic [2:0] S_FLASH   = 3'd4;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

endpackage

// File: rtl/tpc_dwell_timer.sv
// Per-state dwell counter: clears on state entry, counts up, flags the last cycle of a dwell.
module tpc_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] target,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == (target - CNT_W'(1)));

endmodule

// File: rtl/traffic_phase_controller.sv
// Single-approach traffic light sequencer with car-extended green and latched pedestrian WALK.
// Optional flashing-yellow mode is built when TPC_FLASH_MODE_EN is defined.
//
//  state   | meaning
//  ALL_RED | clearance, all approaches red; picks WALK / GREEN / FLASH
//  GREEN   | vehicles go; min dwell, extended by car demand up to max
//  YELLOW  | vehicles clear
//  WALK    | pedestrians cross, lamps red
//  FLASH   | flashing yellow (TPC_FLASH_MODE_EN builds only)
module traffic_phase_controller
  import tpc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 6,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_T   = 2,
  parameter int ALL_RED_T  = 1,
  parameter int WALK_T     = 4,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       car_sensor,
  input  logic       ped_button,
  output logic [2:0] lights,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
`ifdef TPC_FLASH_MODE_EN
  ,
  input  logic       flash_mode
`endif
);

  logic [2:0]       state, next_state;
  logic             entering;
  logic             ped_pending;
  logic             timer_clear, done;
  logic [CNT_W-1:0] target, count;
  logic [2:0]       lights_d;
  logic             walk_d, ack_d;
`ifdef TPC_FLASH_MODE_EN
  logic             flash_phase, flash_phase_d;
`endif

  assign entering = (next_state != state);

`ifdef TPC_FLASH_MODE_EN
  // FLASH reuses the dwell timer as its half-period clock.
  assign timer_clear = entering || ((state == S_FLASH) && done);
`else
  assign timer_clear = entering;
`endif

  always_comb begin
    case (state)
      S_ALL_RED: target = CNT_W'(ALL_RED_T);
      S_GREEN:   target = CNT_W'(GREEN_MAX);
      S_YELLOW:  target = CNT_W'(YELLOW_T);
      S_WALK:    target = CNT_W'(WALK_T);
      default:   target = CNT_W'(FLASH_HALF);
    endcase
  end

  tpc_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .target  (target),
    .done    (done),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_ALL_RED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = S_ALL_RED;
    case (state)
      S_ALL_RED: begin
        next_state = S_ALL_RED;
        if (done) next_state = ped_pending ? S_WALK : S_GREEN;
`ifdef TPC_FLASH_MODE_EN
        if (done && flash_mode) next_state = S_FLASH;
`endif
      end
      S_GREEN: begin
        next_state = S_GREEN;
        if (done) begin
          next_state = S_YELLOW;
        end else if ((count >= CNT_W'(GREEN_MIN - 1)) && (ped_pending || !car_sensor)) begin
          next_state = S_YELLOW;
        end
      end
      S_YELLOW: next_state = done ? S_ALL_RED : S_YELLOW;
      S_WALK:   next_state = done ? S_ALL_RED : S_WALK;
`ifdef TPC_FLASH_MODE_EN
      S_FLASH:  next_state = flash_mode ? S_FLASH : S_ALL_RED;
`endif
      default:  next_state = S_ALL_RED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pending <= 1'b0;
    end else if ((next_state == S_WALK) && (state != S_WALK)) begin
      ped_pending <= 1'b0;
`ifdef TPC_FLASH_MODE_EN
    end else if ((state == S_FLASH) || (next_state == S_FLASH)) begin
      ped_pending <= 1'b0;
`endif
    end else if (ped_button && (state != S_WALK)) begin
      ped_pending <= 1'b1;
    end
  end

  // Outputs are decoded from next_state so they change on the same edge as state.
  always_comb begin
    lights_d = LAMP_RED;
    walk_d   = (next_state == S_WALK);
    ack_d    = (next_state == S_WALK) && (state != S_WALK);
`ifdef TPC_FLASH_MODE_EN
    flash_phase_d = 1'b0;
    if ((next_state == S_FLASH) && (state == S_FLASH)) begin
      flash_phase_d = done ? ~flash_phase : flash_phase;
    end
`endif
    case (next_state)
      S_GREEN:  lights_d = LAMP_GREEN;
      S_YELLOW: lights_d = LAMP_YELLOW;
`ifdef TPC_FLASH_MODE_EN
      S_FLASH:  lights_d = flash_phase_d ? LAMP_OFF : LAMP_YELLOW;
`endif
      default:  lights_d = LAMP_RED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lights  <= LAMP_RED;
      walk    <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      lights  <= lights_d;
      walk    <= walk_d;
      ped_ack <= ack_d;
    end
  end

`ifdef TPC_FLASH_MODE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_phase <= 1'b0;
    end else begin
      flash_phase <= flash_phase_d;
    end
  end
`endif

  assign state_o = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: vector table plus hand-written phase sequences.
module tb_traffic_phase_controller;
  import tpc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       car_sensor = 1'b0;
  logic       ped_button = 1'b0;
  logic [2:0] lights;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state_o;
`ifdef TPC_FLASH_MODE_EN
  logic       flash_mode = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       car;
    logic       ped;
    logic [2:0] lights;
    logic       walk;
    logic       ack;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  traffic_phase_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .car_sensor (car_sensor),
    .ped_button (ped_button),
    .lights     (lights),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .state_o    (state_o)
`ifdef TPC_FLASH_MODE_EN
    ,
    .flash_mode (flash_mode)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Checks that the current cycle and the following n-1 cycles are in st, then steps into the next phase.
  task automatic expect_run(input string name, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]", name, i), {5'd0, state_o}, {5'd0, st});
      step();
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (state_o !== st && n < budget) begin
      step();
      n++;
    end
    chk(name, {5'd0, state_o}, {5'd0, st});
  endtask

  initial begin
    // car, ped -> lights, walk, ack, state
    for (int i = 0; i < 6; i++) vecs.push_back({1'b0, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b0, 1'b0, LAMP_YELLOW, 1'b0, 1'b0, S_YELLOW});
    vecs.push_back({1'b0, 1'b0, LAMP_YELLOW, 1'b0, 1'b0, S_YELLOW});
    vecs.push_back({1'b0, 1'b0, LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    vecs.push_back({1'b0, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b1, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
    vecs.push_back({1'b1, 1'b0, LAMP_YELLOW, 1'b0, 1'b0, S_YELLOW});
    vecs.push_back({1'b1, 1'b0, LAMP_YELLOW, 1'b0, 1'b0, S_YELLOW});
    vecs.push_back({1'b1, 1'b0, LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    vecs.push_back({1'b1, 1'b0, LAMP_RED, 1'b1, 1'b1, S_WALK});
    for (int i = 0; i < 3; i++) vecs.push_back({1'b1, 1'b0, LAMP_RED, 1'b1, 1'b0, S_WALK});
    vecs.push_back({1'b1, 1'b0, LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    vecs.push_back({1'b1, 1'b0, LAMP_GREEN, 1'b0, 1'b0, S_GREEN});

    step();
    chk("reset_state", {lights, walk, ped_ack, state_o}, {LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    step();
    reset_n = 1'b1;

    // Free-running cycle, then a pedestrian pulse at GREEN timer=2 with car demand.
    for (int i = 0; i < vecs.size(); i++) begin
      car_sensor = vecs[i].car;
      ped_button = vecs[i].ped;
      step();
      chk($sformatf("vec%0d", i), {lights, walk, ped_ack, state_o},
          {vecs[i].lights, vecs[i].walk, vecs[i].ack, vecs[i].st});
    end
    ped_button = 1'b0;

    // Car held: green runs to its forced maximum.
    car_sensor = 1'b1;
    expect_run("green_max", S_GREEN, 20);
    expect_run("yellow_after_max", S_YELLOW, 2);
    expect_run("allred_after_max", S_ALL_RED, 1);

    // Button held through WALK must not request a second WALK.
    car_sensor = 1'b0;
    ped_button = 1'b1;
    step();
    ped_button = 1'b0;
    wait_state("reach_walk_a", S_WALK, 20);
    ped_button = 1'b1;
    expect_run("walk_held", S_WALK, 4);
    ped_button = 1'b0;
    expect_run("allred_after_held", S_ALL_RED, 1);
    chk("no_second_walk", {5'd0, state_o}, {5'd0, S_GREEN});

    // Press one cycle after WALK exit is served after the next full vehicle phase.
    car_sensor = 1'b1;
    ped_button = 1'b1;
    step();
    ped_button = 1'b0;
    wait_state("reach_walk_b", S_WALK, 30);
    expect_run("walk_b", S_WALK, 4);
    ped_button = 1'b1;
    step();
    ped_button = 1'b0;
    expect_run("green_late_press", S_GREEN, 6);
    expect_run("yellow_late_press", S_YELLOW, 2);
    expect_run("allred_late_press", S_ALL_RED, 1);
    chk("walk_late_press", {lights, walk, ped_ack, state_o}, {LAMP_RED, 1'b1, 1'b1, S_WALK});

    // Reset mid-GREEN drops outputs at once and loses the pending request.
    wait_state("reach_green_rst", S_GREEN, 20);
    ped_button = 1'b1;
    step();
    ped_button = 1'b0;
    chk("pre_reset_green", {5'd0, state_o}, {5'd0, S_GREEN});
    reset_n = 1'b0;
    #1;
    chk("async_reset", {lights, walk, ped_ack, state_o}, {LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    step();
    reset_n = 1'b1;
    car_sensor = 1'b0;
    expect_run("allred_after_rst", S_ALL_RED, 1);
    expect_run("green_after_rst", S_GREEN, 6);
    expect_run("yellow_after_rst", S_YELLOW, 2);
    expect_run("allred2_after_rst", S_ALL_RED, 1);
    chk("pending_lost", {5'd0, state_o}, {5'd0, S_GREEN});

`ifdef TPC_FLASH_MODE_EN
    wait_state("reach_allred_flash", S_ALL_RED, 20);
    flash_mode = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      logic [2:0] exp_l;
      exp_l = ((i / 4) % 2 == 1) ? LAMP_OFF : LAMP_YELLOW;
      chk($sformatf("flash%0d", i), {2'd0, lights, state_o}, {2'd0, exp_l, S_FLASH});
      ped_button = 1'b1;
      step();
    end
    ped_button = 1'b0;
    flash_mode = 1'b0;
    step();
    chk("flash_exit", {lights, walk, ped_ack, state_o}, {LAMP_RED, 1'b0, 1'b0, S_ALL_RED});
    step();
    chk("flash_no_walk", {lights, walk, ped_ack, state_o}, {LAMP_GREEN, 1'b0, 1'b0, S_GREEN});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
